// File: rtl/vending_machine.sv
`default_nettype none
// ============================================================================
//  Module   : vending_machine
//  Purpose  : Coin-operated vending controller. The item costs 3 units.
//             Credit is tracked by a Moore FSM. Paying 3 units vends the
//             item; paying 4 units vends the item and returns one unit of
//             change. Partial credit is abandoned after TIMEOUT consecutive
//             cycles without a valid coin.
//
//  Parameters
//    TIMEOUT  : consecutive no-coin cycles in RS1/RS2 that abandon the
//               transaction (must be >= 1)
//
//  Ports
//    clk      : in  1  system clock, rising edge
//    rst      : in  1  asynchronous reset, active low
//    in       : in  2  coin code: 0 none, 1 one unit, 2 two units, 3 invalid
//    product  : out 1  item dispensed, one-cycle pulse
//    change   : out 1  one unit of change returned, one-cycle pulse
//
//  Revision : 1.0  initial release
// ============================================================================
module vending_machine #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] in,
    output logic       product,
    output logic       change
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The counter is sized to hold TIMEOUT itself without wrapping.
    localparam int c_CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    // The abandon decision is taken on the edge where the counter would
    // step from TIMEOUT-1 to TIMEOUT, so TIMEOUT idle cycles are tolerated
    // up to but not including the final one.
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    // ------------------------------------------------------------------------
    // State encoding. 3'b010, 3'b100 and 3'b110 are unused and recover to
    // IDLE on the next edge.
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_RS1     = 3'b001,
        S_RS2     = 3'b011,
        S_PRODUCT = 3'b101,
        S_CHANGE  = 3'b111
    } state_e;

    state_e               state_q;
    state_e               state_d;
    logic [c_CNT_W-1:0]   cnt_q;
    logic [c_CNT_W-1:0]   cnt_d;
    logic                 product_q;
    logic                 change_q;

    logic                 w_coin1;
    logic                 w_coin2;
    logic                 w_at_limit;

    assign w_coin1    = (in == 2'd1);
    assign w_coin2    = (in == 2'd2);
    assign w_at_limit = (cnt_q == c_CNT_LAST);

    // ------------------------------------------------------------------------
    // Next-state and timeout counter logic.
    // Counter defaults to 0, which covers "held at 0 in IDLE/PRODUCT/CHANGE",
    // "cleared on entry to RS1/RS2" and "cleared on any valid coin".
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = S_IDLE;
        cnt_d   = '0;

        case (state_q)
            // PRODUCT and CHANGE decide exactly like IDLE so that a coin
            // presented during the vend cycle opens a new transaction.
            S_IDLE, S_PRODUCT, S_CHANGE: begin
                if (w_coin1) begin
                    state_d = S_RS1;
                end else if (w_coin2) begin
                    state_d = S_RS2;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_RS1: begin
                // A valid coin always wins over an expiring timeout.
                if (w_coin1) begin
                    state_d = S_RS2;
                end else if (w_coin2) begin
                    state_d = S_PRODUCT;
                end else if (w_at_limit) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RS1;
                    cnt_d   = cnt_q + c_CNT_ONE;
                end
            end

            S_RS2: begin
                if (w_coin1) begin
                    state_d = S_PRODUCT;
                end else if (w_coin2) begin
                    state_d = S_CHANGE;
                end else if (w_at_limit) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RS2;
                    cnt_d   = cnt_q + c_CNT_ONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register with registered outputs. The output flops are loaded
    // from the decode of the state being entered, so they always equal the
    // decode of state_q and carry no combinational path from 'in'.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            product_q <= 1'b0;
            change_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            product_q <= (state_d == S_PRODUCT) || (state_d == S_CHANGE);
            change_q  <= (state_d == S_CHANGE);
        end
    end

    assign product = product_q;
    assign change  = change_q;

endmodule
`default_nettype wire

// File: tb/tb_vending_machine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vending_machine
//  Purpose  : Self-checking bench for vending_machine. A credit/idle-count
//             reference model predicts every product/change pulse together
//             with the clock cycle it must appear in; a monitor process
//             matches observed pulses against that queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vending_machine;

    localparam int TO = 16;

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic [1:0] in_r = 2'd0;
    logic       product;
    logic       change;

    vending_machine #(.TIMEOUT(TO)) dut (
        .clk     (clk),
        .rst     (rst),
        .in      (in_r),
        .product (product),
        .change  (change)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   stamp;
        logic p;
        logic c;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    int cyc    = 0;
    int n_cmp  = 0;
    int n_bad  = 0;
    int credit = 0;
    int idle   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------------
    // Monitor: runs on the falling edge, away from the sampling edge.
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        if (rst) begin
            while (q.size() > 0 && q[0].stamp < cyc) begin
                mon_e = q.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL missing_pulse: expected product=%b change=%b at cycle %0d, got no pulse",
                         mon_e.p, mon_e.c, mon_e.stamp);
            end
            if (product || change) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL spurious_pulse: cycle %0d got product=%b change=%b, required no pulse",
                             cyc, product, change);
                end else begin
                    mon_e = q.pop_front();
                    if (mon_e.stamp != cyc || product !== mon_e.p || change !== mon_e.c) begin
                        n_bad++;
                        $display("FAIL pulse: cycle %0d got product=%b change=%b, required product=%b change=%b at cycle %0d",
                                 cyc, product, change, mon_e.p, mon_e.c, mon_e.stamp);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Drive one coin code for the next rising edge and advance the model.
    // Model: accumulate credit; reaching 3 vends, reaching 4 also refunds.
    // Partial credit is lost after TO consecutive cycles without a coin.
    // ------------------------------------------------------------------------
    task automatic step(input logic [1:0] v);
        @(negedge clk);
        in_r = v;
        if (v == 2'd1 || v == 2'd2) begin
            credit = credit + int'(v);
            idle   = 0;
            if (credit >= 3) begin
                q.push_back('{stamp: cyc + 1, p: 1'b1, c: (credit == 4)});
                credit = 0;
            end
        end else if (credit != 0) begin
            idle++;
            if (idle == TO) begin
                credit = 0;
                idle   = 0;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) step(2'd0);
    endtask

    // ------------------------------------------------------------------------
    // Assert reset 2 time units after a rising edge (between edges), check
    // the outputs drop at once, hold for n cycles with random input.
    // ------------------------------------------------------------------------
    task automatic pulse_reset(input int n);
        logic ep;
        logic ec;
        @(posedge clk);
        #1;
        ep = 1'b0;
        ec = 1'b0;
        if (q.size() > 0 && q[0].stamp == cyc) begin
            ep = q[0].p;
            ec = q[0].c;
        end
        n_cmp++;
        if (product !== ep || change !== ec) begin
            n_bad++;
            $display("FAIL pre_reset_outputs: got product=%b change=%b, required product=%b change=%b",
                     product, change, ep, ec);
        end
        #1 rst = 1'b0;
        #1;
        n_cmp++;
        if (product !== 1'b0 || change !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: got product=%b change=%b, required 0 0", product, change);
        end
        q.delete();
        credit = 0;
        idle   = 0;
        repeat (n) begin
            @(negedge clk);
            in_r = 2'($urandom_range(0, 3));
            n_cmp++;
            if (product !== 1'b0 || change !== 1'b0) begin
                n_bad++;
                $display("FAIL during_reset: got product=%b change=%b, required 0 0", product, change);
            end
        end
        @(negedge clk);
        rst  = 1'b1;
        in_r = 2'd0;
    endtask

    initial begin
        int r;
        int len;

        #1;
        n_cmp++;
        if (product !== 1'b0 || change !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: got product=%b change=%b, required 0 0", product, change);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Basic purchases
        step(2'd1); step(2'd2);               idle_cycles(3);
        step(2'd2); step(2'd2);               idle_cycles(3);
        step(2'd1); step(2'd1); step(2'd1);   idle_cycles(3);
        step(2'd1); step(2'd1); step(2'd2);   idle_cycles(3);

        // Timeout abandons one unit, then a fresh 2+1 purchase
        step(2'd1); idle_cycles(20); step(2'd2); step(2'd1); idle_cycles(2);
        // 14 idle cycles do not time out
        step(2'd2); idle_cycles(14); step(2'd2); idle_cycles(2);
        // Boundary: coin on the 16th cycle wins, vs. lost after 16 idles
        step(2'd1); idle_cycles(15); step(2'd2); idle_cycles(2);
        step(2'd1); idle_cycles(16); step(2'd2); step(2'd1); idle_cycles(2);
        step(2'd2); idle_cycles(15); step(2'd1); idle_cycles(2);
        // Invalid code never adds credit
        step(2'd1); step(2'd3); step(2'd3); step(2'd2); idle_cycles(2);
        step(2'd3); step(2'd3); step(2'd2); step(2'd1); idle_cycles(2);
        // Back-to-back vending: coins during PRODUCT/CHANGE start anew
        step(2'd2); step(2'd1); step(2'd2); step(2'd2); step(2'd1);
        step(2'd1); step(2'd1); idle_cycles(2);

        // Reset mid-transaction discards credit
        step(2'd1); step(2'd1); pulse_reset(1); step(2'd2); step(2'd2); idle_cycles(2);
        // Reset between edges while the CHANGE pulse is showing
        step(2'd2); step(2'd2); pulse_reset(2); idle_cycles(2);

        // Randomized traffic with idle bursts around the timeout length
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                pulse_reset($urandom_range(1, 3));
            end else if (r < 10) begin
                len = $urandom_range(12, 19);
                for (int k = 0; k < len; k++) begin
                    step(($urandom_range(0, 1) != 0) ? 2'd3 : 2'd0);
                end
            end else begin
                step(2'($urandom_range(0, 3)));
            end
        end

        idle_cycles(3);
        @(negedge clk);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drained: %0d expected pulses never seen, required 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
